// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and helpers for the audio clip player
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        PLAY
    } player_state_t;

    localparam int CLIP_PACK_MAX = 1024;

    function automatic logic [31:0] midscale(input int width);
        return 32'd1 << (width - 1);
    endfunction

    // Extract entry idx (width bits each, entry 0 in the LSBs) from a packed table
    function automatic logic [31:0] clip_field(input logic [CLIP_PACK_MAX-1:0] packed_v,
                                               input int idx, input int width);
        logic [CLIP_PACK_MAX-1:0] shifted;
        shifted = packed_v >> (idx * width);
        return shifted[31:0] & ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/audio_clip_player_divider.sv
// rtl/audio_clip_player_divider.sv - free-running sample-rate divider with terminal-count strobe
module sample_rate_divider #(
    parameter int CLK_DIV_LIMIT = 6249
) (
    input  logic CLK,
    input  logic RESET_N,
    output logic tc
);
    localparam int CW = (CLK_DIV_LIMIT < 1) ? 1 : $clog2(CLK_DIV_LIMIT + 1);

    logic [CW-1:0] count;

    assign tc = (count == CW'(CLK_DIV_LIMIT));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            count <= '0;
        else if (tc)
            count <= '0;
        else
            count <= count + CW'(1);
    end
endmodule

// File: rtl/audio_clip_player.sv
// rtl/audio_clip_player.sv - multi-clip BRAM audio player with play/stop/retrigger/loop
module audio_clip_player
    import audio_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 100_000_000,
    parameter int SAMPLE_RATE_HZ = 16_000,
    parameter int CLK_DIV_LIMIT  = (CLK_FREQ_HZ / SAMPLE_RATE_HZ) - 1,
    parameter int ADDRESS_WIDTH  = 14,
    parameter int SAMPLE_WIDTH   = 8,
    parameter int NUM_CLIPS      = 4,
    parameter int CLIP_SEL_W     = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1,
    parameter logic [NUM_CLIPS*ADDRESS_WIDTH-1:0] CLIP_START = {14'd12000, 14'd8000, 14'd4000, 14'd0},
    parameter logic [NUM_CLIPS*ADDRESS_WIDTH-1:0] CLIP_LEN   = {14'd4000, 14'd4000, 14'd4000, 14'd4000}
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     play_req,
    input  logic [CLIP_SEL_W-1:0]    clip_sel,
    input  logic                     loop_en,
    input  logic                     stop_req,
    output logic [ADDRESS_WIDTH-1:0] bram_addr,
    input  logic [SAMPLE_WIDTH-1:0]  bram_data_out,
    output logic [SAMPLE_WIDTH-1:0]  audio_sample_out,
    output logic                     sample_tick,
    output logic                     busy,
    output logic                     clip_done
);
    localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE = SAMPLE_WIDTH'(midscale(SAMPLE_WIDTH));

    for (genvar i = 0; i < NUM_CLIPS; i++) begin : g_clip_chk
        localparam int S = int'(clip_field(CLIP_PACK_MAX'(CLIP_START), i, ADDRESS_WIDTH));
        localparam int L = int'(clip_field(CLIP_PACK_MAX'(CLIP_LEN), i, ADDRESS_WIDTH));
        if (L < 1) begin : g_len_bad
            $error("audio_clip_player: clip length must be at least 1");
        end
        if (S + L - 1 > (1 << ADDRESS_WIDTH) - 1) begin : g_range_bad
            $error("audio_clip_player: clip extends past the end of the BRAM");
        end
    end

    logic tc;

    sample_rate_divider #(.CLK_DIV_LIMIT(CLK_DIV_LIMIT)) u_divider (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .tc      (tc)
    );

    player_state_t             state, state_n;
    logic [ADDRESS_WIDTH-1:0]  addr_n, start_q, start_n, end_q, end_n;
    logic [ADDRESS_WIDTH-1:0]  sel_start, sel_len;
    logic [SAMPLE_WIDTH-1:0]   sample_n;
    logic                      loop_q, loop_n, done_n, play_ok;

    always_comb begin
        sel_start = '0;
        sel_len   = '0;
        for (int i = 0; i < NUM_CLIPS; i++) begin
            if (clip_sel == CLIP_SEL_W'(i)) begin
                sel_start = ADDRESS_WIDTH'(clip_field(CLIP_PACK_MAX'(CLIP_START), i, ADDRESS_WIDTH));
                sel_len   = ADDRESS_WIDTH'(clip_field(CLIP_PACK_MAX'(CLIP_LEN), i, ADDRESS_WIDTH));
            end
        end
        play_ok = play_req && (32'(clip_sel) < 32'(NUM_CLIPS));
    end

    // Stop beats play, play (retrigger) beats whatever the current state would do
    always_comb begin
        state_n  = state;
        addr_n   = bram_addr;
        sample_n = audio_sample_out;
        start_n  = start_q;
        end_n    = end_q;
        loop_n   = loop_q;
        done_n   = 1'b0;
        if (state == IDLE && tc)
            sample_n = MIDSCALE;
        if (stop_req) begin
            state_n  = IDLE;
            sample_n = MIDSCALE;
            loop_n   = 1'b0;
        end else if (play_ok) begin
            state_n = ARM;
            addr_n  = sel_start;
            start_n = sel_start;
            end_n   = sel_start + sel_len - ADDRESS_WIDTH'(1);
            loop_n  = loop_en;
        end else begin
            case (state)
                ARM: if (tc) state_n = PLAY;
                PLAY: if (tc) begin
                    sample_n = bram_data_out;
                    if (bram_addr != end_q)
                        addr_n = bram_addr + ADDRESS_WIDTH'(1);
                    else if (loop_q)
                        addr_n = start_q;
                    else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state            <= IDLE;
            bram_addr        <= '0;
            audio_sample_out <= MIDSCALE;
            sample_tick      <= 1'b0;
            busy             <= 1'b0;
            clip_done        <= 1'b0;
            loop_q           <= 1'b0;
            start_q          <= '0;
            end_q            <= '0;
        end else begin
            state            <= state_n;
            bram_addr        <= addr_n;
            audio_sample_out <= sample_n;
            sample_tick      <= tc;
            busy             <= (state_n != IDLE);
            clip_done        <= done_n;
            loop_q           <= loop_n;
            start_q          <= start_n;
            end_q            <= end_n;
        end
    end
endmodule

// File: tb/tb_audio_clip_player.sv
// tb/tb_audio_clip_player.sv - scoreboard bench for audio_clip_player
module tb_audio_clip_player;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        play_req = 1'b0;
    logic [1:0]  clip_sel = 2'd0;
    logic        loop_en = 1'b0;
    logic        stop_req = 1'b0;
    logic [13:0] bram_addr;
    logic [7:0]  bram_data_out = 8'd0;
    logic [7:0]  audio_sample_out;
    logic        sample_tick;
    logic        busy;
    logic        clip_done;

    audio_clip_player #(
        .CLK_FREQ_HZ    (100),
        .SAMPLE_RATE_HZ (10),
        .ADDRESS_WIDTH  (14),
        .SAMPLE_WIDTH   (8),
        .NUM_CLIPS      (3),
        .CLIP_START     ({14'd200, 14'd100, 14'd0}),
        .CLIP_LEN       ({14'd1, 14'd2, 14'd3})
    ) dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .play_req         (play_req),
        .clip_sel         (clip_sel),
        .loop_en          (loop_en),
        .stop_req         (stop_req),
        .bram_addr        (bram_addr),
        .bram_data_out    (bram_data_out),
        .audio_sample_out (audio_sample_out),
        .sample_tick      (sample_tick),
        .busy             (busy),
        .clip_done        (clip_done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) bram_data_out <= bram_addr[7:0] + 8'd1;

    typedef struct {
        logic [7:0] s;
        logic       d;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // An empty scoreboard means the player should be idling at midscale
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (RESET_N) begin
            if (clip_done)
                check_eq("done_with_tick", 32'(sample_tick), 32'd1);
            if (sample_tick) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                end else begin
                    e.s = 8'h80;
                    e.d = 1'b0;
                end
                check_eq("sample", 32'(audio_sample_out), 32'(e.s));
                check_eq("clip_done", 32'(clip_done), 32'(e.d));
            end
        end
    end

    task automatic push(input logic [7:0] s, input logic d);
        exp_t e;
        e.s = s;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic cycles(input int k);
        repeat (k) @(negedge CLK);
        #1;
    endtask

    task automatic pulse_play(input int sel, input logic lp);
        play_req = 1'b1;
        clip_sel = 2'(sel);
        loop_en  = lp;
        cycles(1);
        play_req = 1'b0;
        loop_en  = 1'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        forever begin
            @(negedge CLK);
            n++;
            if (sample_tick) break;
            if (n >= 40) begin
                check_eq("tick_timeout", 32'(n), 32'd10);
                break;
            end
        end
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        @(negedge CLK);
        #1;
        check_eq("rst_addr", 32'(bram_addr), 32'd0);
        check_eq("rst_sample", 32'(audio_sample_out), 32'h80);
        check_eq("rst_tick", 32'(sample_tick), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(clip_done), 32'd0);
        cycles(2);
        RESET_N = 1'b1;

        // one-shot clip 0
        wait_tick(n);
        push(8'h80, 0); push(8'd1, 0); push(8'd2, 0); push(8'd3, 1);
        pulse_play(0, 1'b0);
        check_eq("t1_busy_arm", 32'(busy), 32'd1);
        wait_drain();
        check_eq("t1_busy_end", 32'(busy), 32'd0);
        wait_tick(n);

        // looping clip 1 then stop mid-period
        wait_tick(n);
        push(8'h80, 0); push(8'd101, 0); push(8'd102, 0); push(8'd101, 0); push(8'd102, 0);
        pulse_play(1, 1'b1);
        wait_drain();
        cycles(4);
        stop_req = 1'b1;
        cycles(1);
        stop_req = 1'b0;
        check_eq("t2_stop_sample", 32'(audio_sample_out), 32'h80);
        check_eq("t2_stop_busy", 32'(busy), 32'd0);
        wait_tick(n);
        wait_tick(n);

        // retrigger clip 1 while clip 0 is on sample 2
        wait_tick(n);
        push(8'h80, 0); push(8'd1, 0); push(8'd2, 0);
        pulse_play(0, 1'b0);
        wait_drain();
        cycles(3);
        push(8'd2, 0); push(8'd101, 0); push(8'd102, 1);
        pulse_play(1, 1'b0);
        wait_drain();
        check_eq("t3_busy_end", 32'(busy), 32'd0);
        wait_tick(n);

        // stop and play together during PLAY
        wait_tick(n);
        push(8'h80, 0); push(8'd101, 0);
        pulse_play(1, 1'b1);
        wait_drain();
        cycles(2);
        stop_req = 1'b1;
        play_req = 1'b1;
        clip_sel = 2'd0;
        cycles(1);
        stop_req = 1'b0;
        play_req = 1'b0;
        check_eq("t4_sample", 32'(audio_sample_out), 32'h80);
        check_eq("t4_busy", 32'(busy), 32'd0);
        wait_tick(n);
        wait_tick(n);

        // out-of-range clip index is ignored, tick period unaffected
        wait_tick(n);
        pulse_play(3, 1'b0);
        cycles(2);
        check_eq("t5_busy", 32'(busy), 32'd0);
        wait_tick(n);
        wait_tick(n);
        check_eq("t5_period", 32'(n), 32'd10);

        // single-sample clip 2
        push(8'h80, 0); push(8'd201, 1);
        pulse_play(2, 1'b0);
        wait_drain();
        check_eq("len1_busy", 32'(busy), 32'd0);
        wait_tick(n);

        // asynchronous reset on a tc cycle while looping
        wait_tick(n);
        push(8'h80, 0); push(8'd1, 0);
        pulse_play(0, 1'b1);
        wait_drain();
        cycles(9);
        RESET_N = 1'b0;
        #1;
        check_eq("t6_addr", 32'(bram_addr), 32'd0);
        check_eq("t6_sample", 32'(audio_sample_out), 32'h80);
        check_eq("t6_tick", 32'(sample_tick), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_done", 32'(clip_done), 32'd0);
        cycles(2);
        RESET_N = 1'b1;
        wait_tick(n);
        check_eq("t6_first_tick", 32'(n), 32'd10);
        wait_tick(n);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
